// File: rtl/data_mem_ctrl.sv
// ============================================================================
// data_mem_ctrl : single-request data RAM controller with fixed response latency
// Revision 1.0
// ============================================================================
`default_nettype none

module data_mem_ctrl #(
  parameter int DEPTH_WORDS = 4096,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        abort,
  input  logic [3:0]  dmem_wr_en,
  input  logic        dmem_rd_en,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  output logic        dmem_valid,
  output logic [31:0] dmem_rdata,
  output logic        dmem_err,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH_WORDS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [1:0] S_AFTER_ACCEPT = (LATENCY >= 2) ? S_WAIT : S_RESP;
  localparam logic [3:0] CNT_LOAD       = 4'(LATENCY - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] resp_q, resp_d;
  logic        err_q, err_d;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic [AW-1:0] word_idx;
  logic          pending;
  logic          accept;
  logic          out_of_range;
  logic          misaligned;
  logic          rd_and_wr;
  logic          addr_err;
  logic          store_commit;

  assign word_idx     = dmem_addr[AW+1:2];
  assign pending      = dmem_rd_en || (dmem_wr_en != 4'h0);
  assign accept       = rst && (state_q == S_IDLE) && pending && !abort;
  assign out_of_range = (dmem_addr >> (AW + 2)) != 32'd0;
  assign misaligned   = (dmem_addr[1:0] != 2'b00) && (dmem_rd_en || (dmem_wr_en == 4'hF));
  assign rd_and_wr    = dmem_rd_en && (dmem_wr_en != 4'h0);
  assign addr_err     = out_of_range || misaligned;
  // A read+write collision is flagged but the store still lands if the address is good.
  assign store_commit = accept && (dmem_wr_en != 4'h0) && !addr_err;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      resp_q  <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      resp_q  <= resp_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (store_commit) begin
      for (int i = 0; i < 4; i++) begin
        if (dmem_wr_en[i]) begin
          mem_q[word_idx][8*i +: 8] <= dmem_wdata[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_AFTER_ACCEPT;
          cnt_d   = CNT_LOAD;
        end
      end
      S_WAIT: begin
        if (abort) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd1) begin
          state_d = S_RESP;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // The RAM word is captured before the same-edge store, giving read-before-write.
  always_comb begin
    resp_d = resp_q;
    err_d  = err_q;
    if (accept) begin
      resp_d = (dmem_rd_en && !addr_err) ? mem_q[word_idx] : 32'd0;
      err_d  = addr_err || rd_and_wr;
    end
  end

  always_comb begin
    dmem_valid = (state_q == S_RESP);
    dmem_rdata = (state_q == S_RESP) ? resp_q : 32'd0;
    dmem_err   = (state_q == S_RESP) && err_q;
    busy       = (state_q != S_IDLE);
  end

endmodule

`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
// ============================================================================
// tb_data_mem_ctrl : scoreboard bench for data_mem_ctrl (LATENCY 2 and 1)
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        abort = 1'b0;
  logic        sel = 1'b0;
  logic        rd_en = 1'b0;
  logic [3:0]  wr_en = 4'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;

  logic        rd0, rd1;
  logic [3:0]  we0, we1;
  logic        v0, e0, b0, v1, e1, b1;
  logic [31:0] r0, r1;

  assign rd0 = !sel && rd_en;
  assign rd1 = sel && rd_en;
  assign we0 = sel ? 4'h0 : wr_en;
  assign we1 = sel ? wr_en : 4'h0;

  data_mem_ctrl #(.DEPTH_WORDS(4096), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .abort(abort), .dmem_wr_en(we0), .dmem_rd_en(rd0),
    .dmem_addr(addr), .dmem_wdata(wdata), .dmem_valid(v0), .dmem_rdata(r0),
    .dmem_err(e0), .busy(b0)
  );

  data_mem_ctrl #(.DEPTH_WORDS(64), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .abort(abort), .dmem_wr_en(we1), .dmem_rd_en(rd1),
    .dmem_addr(addr), .dmem_wdata(wdata), .dmem_valid(v1), .dmem_rdata(r1),
    .dmem_err(e1), .busy(b1)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
    bit          chk_data;
  } exp_t;

  typedef struct {
    string       nm;
    bit          s;
    logic        rd;
    logic [3:0]  we;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] xd;
    logic        xe;
    int          xl;
  } row_t;

  exp_t sb[$];

  // Drives one request, holds it until the response, then returns to an IDLE cycle.
  task automatic do_req(input bit s, input logic rd, input logic [3:0] we,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rdat, output logic e,
                        output int lat, output logic bsy_after);
    rdat = 32'h0;
    e    = 1'b0;
    lat  = -1;
    @(negedge clk);
    sel   = s;
    rd_en = rd;
    wr_en = we;
    addr  = a;
    wdata = d;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if ((s ? v1 : v0) === 1'b1) begin
        lat  = c;
        rdat = s ? r1 : r0;
        e    = s ? e1 : e0;
        break;
      end
    end
    rd_en = 1'b0;
    wr_en = 4'h0;
    @(posedge clk);
    #1;
    bsy_after = s ? b1 : b0;
  endtask

  task automatic run_rows(input row_t rows[$]);
    logic [31:0] gd;
    logic        ge, gb;
    int          gl;
    exp_t        ex;
    foreach (rows[i]) begin
      sb.push_back('{rows[i].xd, rows[i].xe, bit'(rows[i].rd)});
      do_req(rows[i].s, rows[i].rd, rows[i].we, rows[i].a, rows[i].d, gd, ge, gl, gb);
      ex = sb.pop_front();
      n_tests++;
      if (gl !== rows[i].xl) begin
        n_fail++;
        $display("FAIL %s latency: got %0d expected %0d", rows[i].nm, gl, rows[i].xl);
      end
      n_tests++;
      if (ge !== ex.err) begin
        n_fail++;
        $display("FAIL %s err: got %b expected %b", rows[i].nm, ge, ex.err);
      end
      if (ex.chk_data) begin
        n_tests++;
        if (gd !== ex.data) begin
          n_fail++;
          $display("FAIL %s rdata: got %h expected %h", rows[i].nm, gd, ex.data);
        end
      end
      n_tests++;
      if (gb !== 1'b0) begin
        n_fail++;
        $display("FAIL %s busy_after: got %b expected 0", rows[i].nm, gb);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({v0, r0, e0, b0} !== 35'h0) begin
      n_fail++;
      $display("FAIL reset_l2: got v=%b d=%h e=%b b=%b expected all 0", v0, r0, e0, b0);
    end
    n_tests++;
    if ({v1, r1, e1, b1} !== 35'h0) begin
      n_fail++;
      $display("FAIL reset_l1: got v=%b d=%h e=%b b=%b expected all 0", v1, r1, e1, b1);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic();
    row_t rows[$];
    rows.push_back('{"store_dead", 0, 0, 4'hF, 32'h10, 32'hDEADBEEF, 32'h0, 0, 2});
    rows.push_back('{"load_dead",  0, 1, 4'h0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 2});
    run_rows(rows);
  endtask

  task automatic test_byte_lanes();
    row_t rows[$];
    rows.push_back('{"lane_full",  0, 0, 4'hF, 32'h40, 32'hAABBCCDD, 32'h0, 0, 2});
    rows.push_back('{"lane_b2",    0, 0, 4'h4, 32'h40, 32'h00110000, 32'h0, 0, 2});
    rows.push_back('{"lane_rd1",   0, 1, 4'h0, 32'h40, 32'h0, 32'hAA11CCDD, 0, 2});
    rows.push_back('{"lane_b0_un", 0, 0, 4'h1, 32'h43, 32'h000000EE, 32'h0, 0, 2});
    rows.push_back('{"lane_rd2",   0, 1, 4'h0, 32'h40, 32'h0, 32'hAA11CCEE, 0, 2});
    run_rows(rows);
  endtask

  task automatic test_errors();
    row_t rows[$];
    rows.push_back('{"err_rd_oor",  0, 1, 4'h0, 32'h4000, 32'h0, 32'h0, 1, 2});
    rows.push_back('{"err_wr_mis",  0, 0, 4'hF, 32'h12, 32'h11111111, 32'h0, 1, 2});
    rows.push_back('{"err_wr_oor",  0, 0, 4'hF, 32'h4010, 32'h22222222, 32'h0, 1, 2});
    rows.push_back('{"err_rd_mis",  0, 1, 4'h0, 32'h11, 32'h0, 32'h0, 1, 2});
    rows.push_back('{"err_ram_chk", 0, 1, 4'h0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 2});
    run_rows(rows);
  endtask

  task automatic test_rd_wr_both();
    row_t rows[$];
    rows.push_back('{"rw_init", 0, 0, 4'hF, 32'h20, 32'h1, 32'h0, 0, 2});
    rows.push_back('{"rw_both", 0, 1, 4'hF, 32'h20, 32'h2, 32'h1, 1, 2});
    rows.push_back('{"rw_after", 0, 1, 4'h0, 32'h20, 32'h0, 32'h2, 0, 2});
    run_rows(rows);
  endtask

  task automatic test_abort();
    row_t rows[$];
    bit   seen;
    sel = 1'b0;
    @(negedge clk);
    rd_en = 1'b1;
    addr  = 32'h20;
    @(posedge clk);
    #1;
    n_tests++;
    if (b0 !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_accept busy: got %b expected 1", b0);
    end
    @(negedge clk);
    abort = 1'b1;
    rd_en = 1'b0;
    @(posedge clk);
    #1;
    n_tests++;
    if ({b0, v0} !== 2'b00) begin
      n_fail++;
      $display("FAIL abort_flush busy/valid: got %b%b expected 00", b0, v0);
    end
    @(negedge clk);
    abort = 1'b0;
    seen  = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      if (v0 === 1'b1) seen = 1'b1;
    end
    n_tests++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_no_valid: got valid=1 expected 0");
    end
    @(negedge clk);
    abort = 1'b1;
    rd_en = 1'b1;
    @(posedge clk);
    #1;
    n_tests++;
    if (b0 !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle_block busy: got %b expected 0", b0);
    end
    @(negedge clk);
    abort = 1'b0;
    rd_en = 1'b0;
    rows.push_back('{"abort_next", 0, 1, 4'h0, 32'h20, 32'h0, 32'h2, 0, 2});
    run_rows(rows);
  endtask

  task automatic test_reset_mid();
    sel = 1'b0;
    @(negedge clk);
    rd_en = 1'b1;
    addr  = 32'h10;
    @(posedge clk);
    #1;
    n_tests++;
    if (b0 !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_accept busy: got %b expected 1", b0);
    end
    @(negedge clk);
    rst   = 1'b0;
    rd_en = 1'b0;
    @(posedge clk);
    #1;
    n_tests++;
    if ({v0, r0, e0, b0} !== 35'h0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got v=%b d=%h e=%b b=%b expected all 0", v0, r0, e0, b0);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_back_to_back();
    int   first = -1;
    int   second = -1;
    int   nvalid = 0;
    exp_t ex;
    sel = 1'b0;
    sb.push_back('{32'hDEADBEEF, 1'b0, 1'b1});
    sb.push_back('{32'hDEADBEEF, 1'b0, 1'b1});
    @(negedge clk);
    rd_en = 1'b1;
    addr  = 32'h10;
    for (int c = 1; c <= 15; c++) begin
      @(posedge clk);
      #1;
      if (v0 === 1'b1) begin
        nvalid++;
        if (first < 0) first = c;
        else if (second < 0) second = c;
        if (sb.size() > 0) begin
          ex = sb.pop_front();
          n_tests++;
          if (r0 !== ex.data || e0 !== ex.err) begin
            n_fail++;
            $display("FAIL b2b_resp%0d: got %h/%b expected %h/%b", nvalid, r0, e0, ex.data, ex.err);
          end
        end
      end
      if (first > 0 && c == first + 2) rd_en = 1'b0;
    end
    rd_en = 1'b0;
    n_tests++;
    if (nvalid != 2) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d expected 2", nvalid);
    end
    n_tests++;
    if (first != 2 || second - first != 3) begin
      n_fail++;
      $display("FAIL b2b_timing: got first=%0d second=%0d expected 2 and 5", first, second);
    end
    sb.delete();
  endtask

  task automatic test_latency1();
    row_t rows[$];
    rows.push_back('{"l1_store", 1, 0, 4'hF, 32'h10, 32'hDEADBEEF, 32'h0, 0, 1});
    rows.push_back('{"l1_load",  1, 1, 4'h0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 1});
    run_rows(rows);
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_byte_lanes();
    test_errors();
    test_rd_wr_both();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_latency1();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
